aes_sub_bytes_engine: RTL and testbench

Parametrised, handshaked SubBytes/InvSubBytes unit for the AES datapath. It accepts a full state block and substitutes LANES bytes per clock through forward or inverse S-box lanes selected per block. It returns the substituted block with a valid/ready handshake. The S-box is computed arithmetically in GF(2^8) rather than as a 256-entry table, so lane count can scale without duplicating ROMs.

---
 rtl/aes_pkg.sv | 52 +++++
 rtl/aes_sbox_lane.sv | 22 ++
 rtl/aes_sub_bytes_engine.sv | 153 +++++++++++++++
 tb/tb_aes_sub_bytes_engine.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, GF(2^8) arithmetic, affine maps and the SubBytes engine FSM state.
// Latency: purely combinational functions, no state.
// Backpressure: n/a.
package aes_pkg;

  localparam logic [7:0] AES_POLY     = 8'h1B;
  localparam logic [7:0] AES_AFFINE_C = 8'h63;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUB   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } aes_state_t;

  // Shift-and-add multiply, reducing by x^8 = x^4 + x^3 + x + 1 on each shift.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = '0;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? AES_POLY : 8'h00);
    end
    return acc;
  endfunction

  // Inverse as x^254 (Fermat); naturally maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] t;
    t = gf_mul(x, x);                 // x^2
    t = gf_mul(t, x);                 // x^3
    t = gf_mul(gf_mul(t, t), x);      // x^7
    t = gf_mul(gf_mul(t, t), x);      // x^15
    t = gf_mul(gf_mul(t, t), x);      // x^31
    t = gf_mul(gf_mul(t, t), x);      // x^63
    t = gf_mul(gf_mul(t, t), x);      // x^127
    return gf_mul(t, t);              // x^254
  endfunction

  // Linear part of the AES affine map: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4.
  function automatic logic [7:0] aes_affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]};
  endfunction

  // Inverse of the linear part: rotl1 ^ rotl3 ^ rotl6.
  function automatic logic [7:0] aes_inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]};
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One forward/inverse AES S-box lane computed arithmetically (no lookup table).
// Latency: combinational.
// Backpressure: n/a, no handshake.
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] byte_val,
  input  logic       inverse,
  output logic [7:0] sub_val
);

  // Select forward S(x) or inverse S^-1(x) for this byte.
  always_comb begin
    sub_val = '0;
    if (inverse) begin
      sub_val = gf_inv(aes_inv_affine(byte_val ^ AES_AFFINE_C));
    end else begin
      sub_val = aes_affine(gf_inv(byte_val)) ^ AES_AFFINE_C;
    end
  end

endmodule

// File: rtl/aes_sub_bytes_engine.sv
// Block SubBytes/InvSubBytes engine: LANES bytes substituted per cycle into a work register.
// Latency: BLOCK_BYTES/LANES cycles from acceptance to out_valid, plus one when PIPE=1.
// Backpressure: result held in DONE until out_ready; in_ready low from acceptance to hand-off.
module aes_sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int BLOCK_BYTES = 16,
  parameter int LANES       = 4,
  parameter int PIPE        = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*BLOCK_BYTES-1:0] in_block,
  input  logic                     inverse,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*BLOCK_BYTES-1:0] out_block,
  output logic                     busy
);

  localparam int N  = BLOCK_BYTES / LANES;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $fatal(1, "aes_sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end
  if ((BLOCK_BYTES < LANES) || (BLOCK_BYTES % LANES != 0)) begin : g_bad_block
    $fatal(1, "aes_sub_bytes_engine: BLOCK_BYTES must be a multiple of LANES");
  end
  if (!(PIPE == 0 || PIPE == 1)) begin : g_bad_pipe
    $fatal(1, "aes_sub_bytes_engine: PIPE must be 0 or 1");
  end

  aes_state_t    state;
  logic [KW-1:0] k;
  logic [KW-1:0] pipe_k;
  logic          pipe_vld;
  logic          mode;

  logic [7:0] work       [BLOCK_BYTES];
  logic [7:0] in_bytes   [BLOCK_BYTES];
  logic [7:0] work_sub   [BLOCK_BYTES];
  logic [7:0] work_flush [BLOCK_BYTES];
  logic [7:0] lane_in    [LANES];
  logic [7:0] lane_out   [LANES];
  logic [7:0] pipe_dat   [LANES];

  // Byte g sits in chunk g/LANES and is served by lane g%LANES; byte 0 is the block MSB.
  for (genvar g = 0; g < BLOCK_BYTES; g++) begin : g_byte
    localparam int LN = g % LANES;
    localparam int CH = g / LANES;
    assign in_bytes[g]   = in_block[8*(BLOCK_BYTES-1-g) +: 8];
    assign out_block[8*(BLOCK_BYTES-1-g) +: 8] = work[g];
    assign work_sub[g]   = (k == KW'(CH)) ? lane_out[LN] : work[g];
    assign work_flush[g] = (pipe_k == KW'(CH)) ? pipe_dat[LN] : work[g];
  end

  // Chunk mux: lane g reads byte k*LANES+g of the work register.
  if (N == 1) begin : g_mux_one
    for (genvar g = 0; g < LANES; g++) begin : g_lane_sel
      assign lane_in[g] = work[g];
    end
  end else begin : g_mux
    logic [7:0] col [LANES][N];
    for (genvar g = 0; g < LANES; g++) begin : g_lane_sel
      for (genvar c = 0; c < N; c++) begin : g_chunk
        assign col[g][c] = work[c*LANES + g];
      end
      assign lane_in[g] = col[g][k];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox_lane u_lane (
      .byte_val (lane_in[g]),
      .inverse  (mode),
      .sub_val  (lane_out[g])
    );
  end

  // Control FSM, chunk counter, work/pipe registers and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      pipe_k    <= '0;
      pipe_vld  <= 1'b0;
      mode      <= 1'b0;
      work      <= '{default: '0};
      pipe_dat  <= '{default: '0};
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          if (in_valid && in_ready) begin
            work     <= in_bytes;
            mode     <= inverse;
            k        <= '0;
            pipe_vld <= 1'b0;
            state    <= SUB;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SUB: begin
          if (PIPE == 0) begin
            work <= work_sub;
          end else begin
            // Previous chunk's registered lane results land one edge late.
            if (pipe_vld) work <= work_flush;
            pipe_dat <= lane_out;
            pipe_k   <= k;
            pipe_vld <= 1'b1;
          end
          if (k == K_LAST) begin
            k <= '0;
            if (PIPE == 0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= FLUSH;
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        FLUSH: begin
          work      <= work_flush;
          pipe_vld  <= 1'b0;
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sub_bytes_engine.sv
// Scoreboard bench for aes_sub_bytes_engine across lane/pipe configurations.
// Latency: checks N and N+1 cycle result timing per configuration.
// Backpressure: exercises held out_ready and single hand-off on release.
module tb_aes_sub_bytes_engine;

  localparam int NCFG = 5;
  localparam int CFG_LANES [NCFG] = '{4, 16, 16, 1, 1};
  localparam int CFG_PIPE  [NCFG] = '{0, 0, 1, 0, 1};

  logic         clk;
  logic         rst;
  logic         in_valid  [NCFG];
  logic         in_ready  [NCFG];
  logic [127:0] in_block  [NCFG];
  logic         inverse   [NCFG];
  logic         out_valid [NCFG];
  logic         out_ready [NCFG];
  logic [127:0] out_block [NCFG];
  logic         busy      [NCFG];

  int           n_checks = 0;
  int           n_fail   = 0;
  int           hs_cnt [NCFG];
  logic [127:0] sb_q [$];
  logic [7:0]   sbox_t  [256];
  logic [7:0]   isbox_t [256];

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    aes_sub_bytes_engine #(
      .BLOCK_BYTES (16),
      .LANES       (CFG_LANES[g]),
      .PIPE        (CFG_PIPE[g])
    ) u_dut (
      .clk       (clk),
      .reset     (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_block  (in_block[g]),
      .inverse   (inverse[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_block (out_block[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count output hand-offs per instance.
  always @(posedge clk) begin
    for (int c = 0; c < NCFG; c++) begin
      if (out_valid[c] === 1'b1 && out_ready[c] === 1'b1) hs_cnt[c] = hs_cnt[c] + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference S-box built by walking generator 3 and its inverse, independent of x^254.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
  endtask

  function automatic logic [127:0] model(input logic [127:0] blk, input logic inv);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      b = blk[8*(15-i) +: 8];
      r[8*(15-i) +: 8] = inv ? isbox_t[b] : sbox_t[b];
    end
    return r;
  endfunction

  task automatic run_block(input int c, input logic [127:0] blk, input logic inv,
                           input int exp_lat, input int hold, input bit toggle,
                           output logic [127:0] got);
    logic [127:0] exp;
    int cyc;
    int hs0;
    int bad;
    sb_q.push_back(model(blk, inv));
    cyc = 0;
    while (in_ready[c] !== 1'b1 && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("in_ready_before_accept", in_ready[c], 1);
    in_block[c]  = blk;
    inverse[c]   = inv;
    in_valid[c]  = 1'b1;
    out_ready[c] = (hold == 0);
    @(posedge clk); #1;
    in_valid[c] = 1'b0;
    in_block[c] = ~blk;
    check_eq("busy_after_accept", busy[c], 1);
    cyc = 0;
    while (out_valid[c] !== 1'b1 && cyc < 64) begin
      if (toggle) inverse[c] = ~inverse[c];
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("latency", cyc, exp_lat);
    exp = sb_q.pop_front();
    got = out_block[c];
    check_eq("out_block", got, exp);
    if (hold > 0) begin
      bad = 0;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        if (out_valid[c] !== 1'b1 || out_block[c] !== exp || in_ready[c] !== 1'b0) bad++;
      end
      check_eq("backpressure_violations", bad, 0);
      out_ready[c] = 1'b1;
    end
    hs0 = hs_cnt[c];
    @(posedge clk); #1;
    check_eq("valid_after_handoff", out_valid[c], 0);
    check_eq("in_ready_after_handoff", in_ready[c], 1);
    check_eq("handoff_count", hs_cnt[c] - hs0, 1);
    inverse[c] = 1'b0;
  endtask

  initial begin
    logic [127:0] blk, got, back;
    int lat;
    int seen;

    build_tables();
    rst = 1'b0;
    for (int c = 0; c < NCFG; c++) begin
      in_valid[c] = 1'b0; in_block[c] = '0; inverse[c] = 1'b0; out_ready[c] = 1'b1; hs_cnt[c] = 0;
    end
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < NCFG; c++) begin
      check_eq("rst_in_ready", in_ready[c], 0);
      check_eq("rst_out_valid", out_valid[c], 0);
      check_eq("rst_busy", busy[c], 0);
      check_eq("rst_out_block", out_block[c], 0);
    end
    rst = 1'b0;
    #1 check_eq("in_ready_before_first_edge", in_ready[0], 0);
    @(posedge clk); #1;
    for (int c = 0; c < NCFG; c++) check_eq("in_ready_after_reset", in_ready[c], 1);

    // Known-answer forward and inverse on default configuration.
    blk = {8'h00, 8'h01, 8'h53, 8'h52, {12{8'h00}}};
    run_block(0, blk, 1'b0, 4, 0, 1'b0, got);
    check_eq("fwd_known_answer", got, {8'h63, 8'h7C, 8'hED, 8'h00, {12{8'h63}}});
    blk = {8'h63, 8'h7C, 8'hED, 8'h00, {12{8'hFF}}};
    run_block(0, blk, 1'b1, 4, 0, 1'b0, got);
    check_eq("inv_known_answer", got, {8'h00, 8'h01, 8'h53, 8'h52, {12{8'h7D}}});

    // Exhaustive byte round trip on the wide/narrow, piped/unpiped builds.
    for (int c = 1; c < NCFG; c++) begin
      lat = 16 / CFG_LANES[c] + CFG_PIPE[c];
      for (int b = 0; b < 16; b++) begin
        for (int i = 0; i < 16; i++) blk[8*(15-i) +: 8] = 8'(16*b + i);
        run_block(c, blk, 1'b0, lat, 0, 1'b0, got);
        run_block(c, got, 1'b1, lat, 0, 1'b0, back);
        check_eq("round_trip", back, blk);
      end
    end

    // Back-pressure for 10 cycles.
    blk = {$urandom, $urandom, $urandom, $urandom};
    run_block(0, blk, 1'b0, 4, 10, 1'b0, got);

    // Mode toggled every cycle after acceptance must not matter.
    blk = {$urandom, $urandom, $urandom, $urandom};
    run_block(0, blk, 1'b1, 4, 0, 1'b1, got);
    blk = {$urandom, $urandom, $urandom, $urandom};
    run_block(3, blk, 1'b0, 16, 0, 1'b1, got);

    // Reset asserted during the second SUB cycle.
    blk = {$urandom, $urandom, $urandom, $urandom};
    in_block[0] = blk; inverse[0] = 1'b0; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    check_eq("busy_mid_block", busy[0], 1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_in_ready", in_ready[0], 0);
    check_eq("async_rst_out_valid", out_valid[0], 0);
    check_eq("async_rst_busy", busy[0], 0);
    check_eq("async_rst_out_block", out_block[0], 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid[0] === 1'b1) seen++;
    end
    check_eq("no_valid_after_reset", seen, 0);
    blk = {$urandom, $urandom, $urandom, $urandom};
    run_block(0, blk, 1'b0, 4, 0, 1'b0, got);
    run_block(0, got, 1'b1, 4, 0, 1'b0, back);
    check_eq("post_reset_round_trip", back, blk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
